// File: rtl/gcd_requester.sv
// ============================================================================
// gcd_requester : initiator for the GCD engine's serial operand-load protocol.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gcd_requester #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [W-1:0]  req_a,
    input  logic [W-1:0]  req_b,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          res_timeout,
    output logic          gcd_start,
    output logic [W-1:0]  gcd_data,
    input  logic          gcd_done,
    input  logic [W-1:0]  gcd_result,
    output logic          busy,
    output logic [CW-1:0] txn_count
);

    localparam int              CNTW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CW-1:0]   TXN_ONE  = CW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q;
    logic [W-1:0]    res_data_q, res_data_d;
    logic            res_to_q, res_to_d;
    logic [CW-1:0]   txn_q, txn_d;
    logic            w_done_rise;

    // Only a fresh 0->1 transition counts, so a done level left over from a
    // previous operation is never mistaken for completion.
    assign w_done_rise = gcd_done && !done_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        res_data_d = res_data_q;
        res_to_d   = res_to_q;
        txn_d      = txn_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    a_d = req_a;
                    b_d = req_b;
                    // gcd(0,x)=x and gcd(0,0)=0, so the engine is bypassed
                    if ((req_a == '0) || (req_b == '0)) begin
                        res_data_d = req_a | req_b;
                        res_to_d   = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (w_done_rise) begin
                    res_data_d = gcd_result;
                    res_to_d   = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_to_d   = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    txn_d   = txn_q + TXN_ONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            res_data_q <= '0;
            res_to_q   <= 1'b0;
            txn_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            done_q     <= gcd_done;
            res_data_q <= res_data_d;
            res_to_q   <= res_to_d;
            txn_q      <= txn_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign res_valid   = (state_q == S_RESP);
    assign gcd_start   = (state_q == S_LOAD_A);
    assign busy        = (state_q != S_IDLE);
    assign gcd_data    = (state_q == S_LOAD_A) ? a_q :
                         ((state_q == S_LOAD_B) || (state_q == S_WAIT)) ? b_q : '0;
    assign res_data    = res_data_q;
    assign res_timeout = res_to_q;
    assign txn_count   = txn_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_requester.sv
// ============================================================================
// tb_gcd_requester : directed bench with a cycle-timeline reference model.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gcd_requester;

    localparam int W       = 16;
    localparam int CW      = 16;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          gcd_done = 1'b0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic [W-1:0]  gcd_result = '0;
    logic          req_ready, res_valid, res_timeout, gcd_start, busy;
    logic [W-1:0]  res_data, gcd_data;
    logic [CW-1:0] txn_count;

    gcd_requester #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .gcd_start(gcd_start), .gcd_data(gcd_data),
        .gcd_done(gcd_done), .gcd_result(gcd_result), .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    int cmp_count = 0;
    int err_count = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        cmp_count++;
        err_count++;
        $display("FAIL %s @%0t: wait bound expired", name, $time);
    endtask

    // Engine model: 0 = normal (drops done on start, raises 4 cycles into
    // its wait), 1 = holds stale done, drops then re-raises, 2 = never done.
    int           eng_mode = 0;
    int           e_phase = 0;
    int           e_cnt = 0;
    logic [W-1:0] e_a = '0;
    logic [W-1:0] e_b = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            gcd_done = 1'b0;
            e_phase  = 0;
        end else if (gcd_start) begin
            e_a     = gcd_data;
            e_phase = 1;
            e_cnt   = 0;
            if (eng_mode != 1) gcd_done = 1'b0;
        end else if (e_phase == 1) begin
            e_b     = gcd_data;
            e_phase = 2;
            e_cnt   = 0;
        end else if (e_phase == 2) begin
            e_cnt++;
            if (eng_mode == 0 && e_cnt == 4) begin
                gcd_result = ref_gcd(e_a, e_b);
                gcd_done   = 1'b1;
                e_phase    = 0;
            end else if (eng_mode == 1 && e_cnt == 3) begin
                gcd_done = 1'b0;
            end else if (eng_mode == 1 && e_cnt == 6) begin
                gcd_result = ref_gcd(e_a, e_b);
                gcd_done   = 1'b1;
                e_phase    = 0;
            end
        end
    end

    // Reference timeline: accept in cycle n -> LOAD_A n+1, LOAD_B n+2, WAIT
    // from n+3; response the cycle after a fresh done rise or after TIMEOUT
    // wait cycles; zero operands respond at n+1.
    bit           m_act = 1'b0;
    bit           m_resp = 1'b0;
    bit           m_to = 1'b0;
    bit           m_dprev = 1'b0;
    int           m_acc = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_res = '0;
    logic [CW-1:0] m_cnt = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_timeout", res_timeout, 0);
            chk("rst_gcd_start", gcd_start, 0);
            chk("rst_gcd_data", gcd_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_txn_count", txn_count, 0);
            m_act   = 1'b0;
            m_resp  = 1'b0;
            m_cnt   = '0;
            m_dprev = 1'b0;
        end else begin
            if (!m_act) begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_res_valid", res_valid, 0);
                chk("idle_gcd_start", gcd_start, 0);
                chk("idle_gcd_data", gcd_data, 0);
            end else if (m_resp) begin
                chk("resp_res_valid", res_valid, 1);
                chk("resp_req_ready", req_ready, 0);
                chk("resp_busy", busy, 1);
                chk("resp_gcd_start", gcd_start, 0);
                chk("resp_gcd_data", gcd_data, 0);
                chk("resp_res_data", res_data, m_res);
                chk("resp_res_timeout", res_timeout, m_to);
            end else begin
                chk("run_res_valid", res_valid, 0);
                chk("run_req_ready", req_ready, 0);
                chk("run_busy", busy, 1);
                chk("run_gcd_start", gcd_start, (cyc == m_acc + 1) ? 1 : 0);
                chk("run_gcd_data", gcd_data, (cyc == m_acc + 1) ? m_a : m_b);
            end
            chk("txn_count", txn_count, m_cnt);

            if (m_act && !m_resp) begin
                if (cyc >= m_acc + 3 && gcd_done && !m_dprev) begin
                    m_resp = 1'b1;
                    m_res  = ref_gcd(m_a, m_b);
                    m_to   = 1'b0;
                end else if (cyc == m_acc + 3 + TIMEOUT - 1) begin
                    m_resp = 1'b1;
                    m_res  = '0;
                    m_to   = 1'b1;
                end
            end else if (m_act && m_resp) begin
                if (res_ready) begin
                    m_cnt = m_cnt + 1'b1;
                    m_act = 1'b0;
                end
            end else if (req_valid) begin
                m_act = 1'b1;
                m_acc = cyc;
                m_a   = req_a;
                m_b   = req_b;
                if (req_a == 0 || req_b == 0) begin
                    m_resp = 1'b1;
                    m_res  = req_a | req_b;
                    m_to   = 1'b0;
                end else begin
                    m_resp = 1'b0;
                end
            end
            m_dprev = gcd_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int accc);
        bit ok;
        ok    = 1'b0;
        accc  = 0;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok   = 1'b1;
                accc = cyc;
            end
            tick();
            if (ok) break;
        end
        req_valid = 1'b0;
        if (!ok) bound_fail("req_accept");
    endtask

    task automatic recv(input int hold, output logic [W-1:0] d, output logic t, output int rvc);
        bit got;
        got = 1'b0;
        d   = '0;
        t   = 1'b0;
        rvc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                rvc = cyc;
                break;
            end
        end
        if (!got) begin
            bound_fail("res_valid_wait");
        end else begin
            tick();
            repeat (hold) tick();
            res_ready = 1'b1;
            @(negedge clk);
            d = res_data;
            t = res_timeout;
            tick();
            res_ready = 1'b0;
        end
    endtask

    initial begin
        int           acc, rv;
        logic [W-1:0] d;
        logic         t;

        @(posedge clk);
        #2;
        chk("init_req_ready", req_ready, 1);
        chk("init_txn_count", txn_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic: 143,78 -> 13, response 7 cycles after accept
        send(16'd143, 16'd78, acc);
        recv(0, d, t, rv);
        chk("basic_data", d, 13);
        chk("basic_timeout", t, 0);
        chk("basic_latency", rv - acc, 7);
        chk("basic_txn", txn_count, 1);

        // Back-to-back with backpressure on the first
        send(16'd48, 16'd18, acc);
        recv(5, d, t, rv);
        chk("b2b1_data", d, 6);
        send(16'd17, 16'd5, acc);
        recv(0, d, t, rv);
        chk("b2b2_data", d, 1);
        chk("b2b_txn", txn_count, 3);

        // Zero-operand bypass
        send(16'd0, 16'd78, acc);
        recv(0, d, t, rv);
        chk("zero_a_data", d, 78);
        chk("zero_latency", rv - acc, 1);
        send(16'd0, 16'd0, acc);
        recv(0, d, t, rv);
        chk("zero_both_data", d, 0);
        send(16'd91, 16'd0, acc);
        recv(1, d, t, rv);
        chk("zero_b_data", d, 91);
        chk("zero_txn", txn_count, 6);

        // Stale done: level held from prior op, only the later rise counts
        eng_mode = 1;
        send(16'd21, 16'd14, acc);
        recv(0, d, t, rv);
        chk("stale_data", d, 7);
        chk("stale_latency", rv - acc, 9);

        // Timeout: engine never completes
        eng_mode = 2;
        send(16'd40, 16'd30, acc);
        recv(2, d, t, rv);
        chk("to_data", d, 0);
        chk("to_flag", t, 1);
        chk("to_latency", rv - acc, 3 + TIMEOUT);
        chk("to_txn", txn_count, 8);

        // Asynchronous reset in the middle of WAIT
        eng_mode = 0;
        send(16'd143, 16'd78, acc);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_gcd_data", gcd_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_txn_count", txn_count, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        send(16'd12, 16'd8, acc);
        recv(0, d, t, rv);
        chk("post_rst_data", d, 4);
        chk("post_rst_txn", txn_count, 1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout @%0t: simulation bound expired", $time);
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
